// File: rtl/dram_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the SDRAM
// controller. The arbiter takes the slave view; the environment (masters plus
// controller) takes the master view.
//
// Handshake: a master raises rd or wr (level) with addr/wdata and holds it
// until it sees a one-cycle ack; it must drop the request in the ack cycle.
// Toward the controller, dram_req_read/dram_req_write stay high with stable
// dram_addr/dram_wdata until a one-cycle dram_data_valid completes the access.
interface dram_bus_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_rd;
    logic              m0_wr;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_rd;
    logic              m1_wr;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              dram_req_read;
    logic              dram_req_write;
    logic [DATA_W-1:0] dram_rdata;
    logic              dram_data_valid;

    logic [1:0]        grant;
    logic              timeout_err;

    modport slave (
        input  m0_addr, m0_wdata, m0_rd, m0_wr,
        output m0_rdata, m0_ack,
        input  m1_addr, m1_wdata, m1_rd, m1_wr,
        output m1_rdata, m1_ack,
        output dram_addr, dram_wdata, dram_req_read, dram_req_write,
        input  dram_rdata, dram_data_valid,
        output grant, timeout_err
    );

    modport master (
        output m0_addr, m0_wdata, m0_rd, m0_wr,
        input  m0_rdata, m0_ack,
        output m1_addr, m1_wdata, m1_rd, m1_wr,
        input  m1_rdata, m1_ack,
        input  dram_addr, dram_wdata, dram_req_read, dram_req_write,
        output dram_rdata, dram_data_valid,
        input  grant, timeout_err
    );
endinterface

// File: rtl/dram_bus_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller. Each access
// runs IDLE -> ACCESS -> DONE; a hung controller is cut off after TIMEOUT
// cycles in ACCESS and the owner gets 32'hDEADBEEF with a sticky error flag.
module dram_bus_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    dram_bus_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter is wide enough to hold TIMEOUT; one bit minimum when disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

    state_t           state;
    logic             prio_m1;   // 1: m1 wins the next tie
    logic             own1;      // owner of the access in flight
    logic [CNT_W-1:0] cnt;

    logic req0, req1, pick1, pick_wr, timed_out;

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        req0      = bus.m0_rd | bus.m0_wr;
        req1      = bus.m1_rd | bus.m1_wr;
        pick1     = req1 & (~req0 | prio_m1);
        pick_wr   = pick1 ? bus.m1_wr : bus.m0_wr;
        timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
    end

    assign dbg_state = state;

    // Access FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            prio_m1            <= 1'b0;
            own1               <= 1'b0;
            cnt                <= '0;
            bus.m0_rdata       <= DATA_ZERO;
            bus.m1_rdata       <= DATA_ZERO;
            bus.m0_ack         <= 1'b0;
            bus.m1_ack         <= 1'b0;
            bus.dram_addr      <= ADDR_ZERO;
            bus.dram_wdata     <= DATA_ZERO;
            bus.dram_req_read  <= 1'b0;
            bus.dram_req_write <= 1'b0;
            bus.grant          <= 2'b00;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        bus.dram_addr      <= pick1 ? bus.m1_addr : bus.m0_addr;
                        bus.dram_wdata     <= pick1 ? bus.m1_wdata : bus.m0_wdata;
                        bus.dram_req_write <= pick_wr;
                        bus.dram_req_read  <= ~pick_wr;
                        bus.grant          <= pick1 ? 2'b10 : 2'b01;
                        own1               <= pick1;
                        prio_m1            <= ~pick1;
                        cnt                <= '0;
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.dram_data_valid) begin
                        if (!bus.dram_req_write) begin
                            if (own1) bus.m1_rdata <= bus.dram_rdata;
                            else      bus.m0_rdata <= bus.dram_rdata;
                        end
                        if (own1) bus.m1_ack <= 1'b1;
                        else      bus.m0_ack <= 1'b1;
                        bus.dram_req_read  <= 1'b0;
                        bus.dram_req_write <= 1'b0;
                        bus.grant          <= 2'b00;
                        state              <= DONE;
                    end else if (timed_out) begin
                        if (own1) begin
                            bus.m1_rdata <= ABORT_DATA;
                            bus.m1_ack   <= 1'b1;
                        end else begin
                            bus.m0_rdata <= ABORT_DATA;
                            bus.m0_ack   <= 1'b1;
                        end
                        bus.dram_req_read  <= 1'b0;
                        bus.dram_req_write <= 1'b0;
                        bus.grant          <= 2'b00;
                        bus.timeout_err    <= 1'b1;
                        state              <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Random two-master traffic against a transaction-level model: each access is
// planned when it is won (winner, latched fields, controller delay, expected
// read data), then every cycle the bus outputs are compared with that plan.
module tb_dram_bus_arbiter;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 8;
    localparam int N_CYCLES = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    dram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    int                owner;      // -1 when no access is planned
    int                acc_g;      // first cycle of the access
    int                ack_c;      // cycle the ack must appear
    int                resp_c;     // cycle the controller pulses valid
    int                last_win;
    logic              acc_wr;
    logic              acc_to;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] hold_rdata [2];
    logic              exp_terr;
    logic [DATA_W-1:0] exp_q [$];

    // Master stimulus state
    logic              req_on [2];
    logic              req_rd [2];
    logic              req_wr [2];
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_wdata [2];

    task automatic model_reset();
        owner = -1; ack_c = -1; resp_c = -1; acc_g = 0;
        last_win = 1;
        hold_rdata[0] = '0; hold_rdata[1] = '0;
        exp_terr = 1'b0;
        exp_q.delete();
        for (int m = 0; m < 2; m++) begin
            req_on[m] = 1'b0; req_rd[m] = 1'b0; req_wr[m] = 1'b0;
            req_addr[m] = '0; req_wdata[m] = '0;
        end
    endtask

    task automatic drive_masters();
        bus.m0_rd    = req_on[0] & req_rd[0];
        bus.m0_wr    = req_on[0] & req_wr[0];
        bus.m0_addr  = req_addr[0];
        bus.m0_wdata = req_wdata[0];
        bus.m1_rd    = req_on[1] & req_rd[1];
        bus.m1_wr    = req_on[1] & req_wr[1];
        bus.m1_addr  = req_addr[1];
        bus.m1_wdata = req_wdata[1];
    endtask

    task automatic new_request(input int m);
        int op;
        op = $urandom_range(0, 2);
        req_on[m]    = 1'b1;
        req_rd[m]    = (op != 1);
        req_wr[m]    = (op != 0);
        req_addr[m]  = ADDR_W'($urandom);
        req_wdata[m] = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {bus.grant, bus.dram_req_read, bus.dram_req_write,
                              bus.m1_ack, bus.m0_ack, bus.timeout_err}, 64'h0);
        check({tag, "_rdata"}, {bus.m1_rdata, bus.m0_rdata}, 64'h0);
        check({tag, "_addr"}, bus.dram_addr, 64'h0);
        check({tag, "_wdata"}, bus.dram_wdata, 64'h0);
    endtask

    // One clock: compare outputs, then drive the inputs for this cycle and
    // plan any access they win.
    task automatic step();
        logic [1:0] e_grant, e_ack;
        logic       e_rr, e_rw, done_now;
        int         acked, w, d;
        @(negedge clk);
        cyc++;
        e_grant = 2'b00; e_ack = 2'b00; e_rr = 1'b0; e_rw = 1'b0;
        done_now = (owner >= 0) && (cyc == ack_c);
        acked = done_now ? owner : -1;
        if (done_now) begin
            e_ack[owner] = 1'b1;
            if (exp_q.size() > 0) hold_rdata[owner] = exp_q.pop_front();
            if (acc_to) exp_terr = 1'b1;
        end else if (owner >= 0) begin
            e_grant[owner] = 1'b1;
            e_rr = ~acc_wr;
            e_rw = acc_wr;
            check("dram_addr", bus.dram_addr, acc_addr);
            check("dram_wdata", bus.dram_wdata, acc_wdata);
        end
        check("ctl{grant,rd,wr,ack1,ack0,terr}",
              {bus.grant, bus.dram_req_read, bus.dram_req_write, bus.m1_ack, bus.m0_ack, bus.timeout_err},
              {e_grant, e_rr, e_rw, e_ack[1], e_ack[0], exp_terr});
        check("m0_rdata", bus.m0_rdata, hold_rdata[0]);
        check("m1_rdata", bus.m1_rdata, hold_rdata[1]);

        if (done_now) begin
            owner = -1;
            ack_c = -1;
        end

        // Masters: drop on ack, wiggle held fields, occasionally start anew.
        for (int m = 0; m < 2; m++) begin
            if (m == acked) begin
                req_on[m] = 1'b0;
            end else if (req_on[m]) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_addr[m]  = ADDR_W'($urandom);
                    req_wdata[m] = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_request(m);
            end
        end
        drive_masters();

        // Controller: planned response, plus stray pulses while nothing is in flight.
        bus.dram_rdata      = $urandom;
        bus.dram_data_valid = 1'b0;
        if (cyc == resp_c) begin
            bus.dram_data_valid = 1'b1;
            bus.dram_rdata      = resp_data;
        end else if (owner < 0 && $urandom_range(0, 7) == 0) begin
            bus.dram_data_valid = 1'b1;
        end

        // Arbitration at the end of an idle cycle.
        if (owner < 0 && !done_now && (req_on[0] || req_on[1])) begin
            if (req_on[0] && req_on[1]) w = 1 - last_win;
            else                        w = req_on[1] ? 1 : 0;
            last_win  = w;
            owner     = w;
            acc_g     = cyc + 1;
            acc_addr  = req_addr[w];
            acc_wdata = req_wdata[w];
            acc_wr    = req_wr[w];
            d         = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 4)
                                                    : $urandom_range(0, TIMEOUT - 1);
            resp_data = $urandom;
            resp_c    = (d <= TIMEOUT + 1) ? acc_g + d : -1;
            acc_to    = (d >= TIMEOUT);
            ack_c     = acc_to ? acc_g + TIMEOUT : acc_g + d + 1;
            if (acc_to)      exp_q.push_back(32'hDEADBEEF);
            else if (acc_wr) exp_q.push_back(hold_rdata[w]);
            else             exp_q.push_back(resp_data);
        end
    endtask

    // Asynchronous reset in the middle of an access.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        drive_masters();
        bus.dram_data_valid = 1'b0;
        @(negedge clk);
        cyc++;
        check_all_zero("rst_held");
        rst_n = 1'b1;
        req_on[1]    = 1'b1;
        req_rd[1]    = 1'b1;
        req_wr[1]    = 1'b0;
        req_addr[1]  = ADDR_W'($urandom);
    endtask

    // Main sequence
    initial begin
        int resets_left;
        model_reset();
        drive_masters();
        bus.dram_rdata      = '0;
        bus.dram_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Tie on the very first arbitration: m0 must go first.
        for (int m = 0; m < 2; m++) begin
            req_on[m] = 1'b1; req_rd[m] = 1'b1; req_wr[m] = 1'b0;
            req_addr[m] = ADDR_W'(24'h000010 + m);
            req_wdata[m] = '0;
        end

        resets_left = 3;
        for (int i = 0; i < N_CYCLES; i++) begin
            step();
            if (resets_left > 0 && i > 500 && owner >= 0 && cyc >= acc_g + 1 &&
                $urandom_range(0, 40) == 0) begin
                resets_left--;
                mid_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
